// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - FIR output rescale/saturate, warm-up drop, output FIFO with valid/ready
// Optional feature macro: FIR_REQUANT_SAT_EN (clip to OUT_W range and raise sat_flag; otherwise wrap)
module fir_out_requant #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 3,
    parameter int WARMUP     = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_W-1:0]               y_in,
    input  logic                          y_valid,
    output logic [OUT_W-1:0]              s_data,
    output logic                          s_valid,
    input  logic                          s_ready,
    output logic                          warm_done,
    output logic                          sat_flag,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int WCW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int HALF_I = (2 ** SHIFT) / 2;
    localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(HALF_I);

    logic signed [IN_W:0]  y_ext;
    logic [OUT_W-1:0]      q;
    logic [WCW-1:0]        warm_cnt;
    logic                  stage_v;
    logic [OUT_W-1:0]      stage_d;
    logic [OUT_W-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  capture;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic                  drop;

    // One extra bit keeps the rounding add from overflowing at the positive limit.
    assign y_ext = $signed({y_in[IN_W-1], y_in});

`ifdef FIR_REQUANT_SAT_EN
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W:0] r;
    logic                 clip_hi;
    logic                 clip_lo;

    assign r       = (y_ext + HALF) >>> SHIFT;
    assign clip_hi = (r > MAXV);
    assign clip_lo = (r < MINV);

    always_comb begin
        q = r[OUT_W-1:0];
        if (clip_hi) begin
            q = MAXV[OUT_W-1:0];
        end else if (clip_lo) begin
            q = MINV[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else if (capture && (clip_hi || clip_lo)) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign q        = OUT_W'((y_ext + HALF) >>> SHIFT);
    assign sat_flag = 1'b0;
`endif

    assign warm_done = (warm_cnt == '0);
    assign capture   = y_valid && warm_done;

    assign s_valid = (fifo_level != '0);
    assign s_data  = s_valid ? mem[rd_ptr] : '0;
    assign pop     = s_valid && s_ready;
    assign full    = (fifo_level == (PW + 1)'(FIFO_DEPTH));
    // A full FIFO still accepts the staged sample when the head leaves on the same edge.
    assign push_ok = stage_v && (!full || pop);
    assign drop    = stage_v && full && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            warm_cnt   <= WCW'(WARMUP);
            stage_v    <= 1'b0;
            stage_d    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (y_valid && !warm_done) begin
                warm_cnt <= warm_cnt - WCW'(1);
            end
            stage_v <= capture;
            if (capture) begin
                stage_d <= q;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + (PW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (PW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= stage_d;
        end
    end
endmodule

// File: tb/tb_fir_out_requant.sv
// tb/tb_fir_out_requant.sv - self-checking bench for fir_out_requant against a queue-based model
module tb_fir_out_requant;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 3;
    localparam int WARMUP = 5;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [IN_W-1:0]  y_in = '0;
    logic             y_valid = 1'b0;
    logic             s_ready = 1'b0;
    logic [OUT_W-1:0] s_data;
    logic             s_valid;
    logic             warm_done;
    logic             sat_flag;
    logic [CNT_W-1:0] drop_cnt;
    logic [$clog2(DEPTH):0] fifo_level;

    fir_out_requant #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .warm_done(warm_done), .sat_flag(sat_flag),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: output FIFO as a queue, one-deep stage, warm-up count, counters.
    int mq[$];
    int got[$];
    int m_warm = WARMUP;
    bit m_stv = 1'b0;
    int m_std = 0;
    int m_drop = 0;
    bit m_sat = 1'b0;

    function automatic int requant(input int y, output bit clip);
        int d;
        int t;
        int r;
        d = 2 ** SHIFT;
        t = y + d / 2;
        if (t >= 0) r = t / d;
        else        r = -((-t + d - 1) / d);
        clip = 1'b0;
`ifdef FIR_REQUANT_SAT_EN
        if (r > 2 ** (OUT_W - 1) - 1) begin
            r = 2 ** (OUT_W - 1) - 1;
            clip = 1'b1;
        end else if (r < -(2 ** (OUT_W - 1))) begin
            r = -(2 ** (OUT_W - 1));
            clip = 1'b1;
        end
`else
        r = r % (2 ** OUT_W);
        if (r < 0) r = r + 2 ** OUT_W;
        if (r >= 2 ** (OUT_W - 1)) r = r - 2 ** OUT_W;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input int y, input bit rdy);
        bit clip;
        bit pop;
        bit full;
        int val;
        reset   = rst_n;
        y_valid = v;
        y_in    = y[IN_W-1:0];
        s_ready = rdy;
        if (s_valid === 1'b1 && rdy && rst_n) got.push_back(int'($signed(s_data)));
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_warm = WARMUP;
            m_stv  = 1'b0;
            m_drop = 0;
            m_sat  = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (m_stv) begin
                if (full && !pop) begin
                    if (m_drop < 2 ** CNT_W - 1) m_drop++;
                end else begin
                    mq.push_back(m_std);
                end
            end
            val   = requant(int'($signed(y[IN_W-1:0])), clip);
            m_stv = v && (m_warm == 0);
            if (m_stv) begin
                m_std = val;
                if (clip) m_sat = 1'b1;
            end
            if (v && m_warm > 0) m_warm--;
        end
        @(negedge clk);
        chk("s_valid", int'(s_valid), int'(mq.size() > 0));
        chk("s_data", int'($signed(s_data)), (mq.size() > 0) ? mq[0] : 0);
        chk("fifo_level", int'(fifo_level), mq.size());
        chk("drop_cnt", int'(drop_cnt), m_drop);
        chk("warm_done", int'(warm_done), int'(m_warm == 0));
        chk("sat_flag", int'(sat_flag), int'(m_sat));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, rdy);
    endtask

    initial begin
        int yv;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_s_valid", int'(s_valid), 0);
        chk("rst_warm_done", int'(warm_done), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);

        // Warm-up: seven samples of 8, only the last two survive as value 1.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8, 1'b0);
        idle(2, 1'b0);
        chk("warm_level", int'(fifo_level), 2);
        chk("warm_head", int'($signed(s_data)), 1);
        chk("warm_done_set", int'(warm_done), 1);
        chk("warm_no_drop", int'(drop_cnt), 0);
        got.delete();
        idle(3, 1'b1);
        chk("warm_out_cnt", got.size(), 2);

        // Rounding cases.
        got.delete();
        step(1'b1, 1'b1, 100, 1'b1);
        step(1'b1, 1'b1, -100, 1'b1);
        step(1'b1, 1'b1, 0, 1'b1);
        step(1'b1, 1'b1, -4, 1'b1);
        idle(4, 1'b1);
        chk("round_cnt", got.size(), 4);
        if (got.size() == 4) begin
            chk("round_0", got[0], 13);
            chk("round_1", got[1], -12);
            chk("round_2", got[2], 0);
            chk("round_3", got[3], 0);
        end
        chk("round_sat", int'(sat_flag), 0);

        // Out-of-range samples.
        got.delete();
        step(1'b1, 1'b1, 2000, 1'b1);
        step(1'b1, 1'b1, -2000, 1'b1);
        step(1'b1, 1'b1, 8, 1'b1);
        idle(4, 1'b1);
        chk("big_cnt", got.size(), 3);
        if (got.size() == 3) begin
`ifdef FIR_REQUANT_SAT_EN
            chk("big_pos", got[0], 127);
            chk("big_neg", got[1], -128);
`else
            chk("big_pos", got[0], -6);
            chk("big_neg", got[1], 6);
`endif
            chk("big_after", got[2], 1);
        end
`ifdef FIR_REQUANT_SAT_EN
        chk("sat_sticky", int'(sat_flag), 1);
`else
        chk("sat_tied", int'(sat_flag), 0);
`endif

        // Overflow: ten samples into a stalled depth-8 FIFO.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16 * (i + 1), 1'b0);
        idle(1, 1'b0);
        chk("full_level", int'(fifo_level), 8);
        chk("full_drops", int'(drop_cnt), 2);
        chk("full_head", int'($signed(s_data)), 2);
        got.delete();
        idle(10, 1'b1);
        chk("drain_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) chk("drain_order", got[i], 2 * (i + 1));

        // Full FIFO with simultaneous push and pop keeps its level.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 8, 1'b0);
        chk("fill_level", int'(fifo_level), 8);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16 * i, 1'b1);
        chk("pp_level", int'(fifo_level), 8);
        chk("pp_drops", int'(drop_cnt), 2);
        idle(12, 1'b1);

        // Reset with data buffered and staged, then warm-up restarts.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 40, 1'b0);
        chk("pre_rst_level", int'(fifo_level), 4);
        step(1'b0, 1'b1, 40, 1'b0);
        chk("mid_rst_valid", int'(s_valid), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_drops", int'(drop_cnt), 0);
        chk("mid_rst_warm", int'(warm_done), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 40, 1'b0);
        idle(2, 1'b0);
        chk("rewarm_level", int'(fifo_level), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) yv = int'($urandom_range(0, 2400)) - 1200;
            else                           yv = int'($urandom_range(0, 65535)) - 32768;
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), yv,
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
Output-side consumer of the 5-tap FIR sample stream. Takes the 16-bit signed filter result each sample strobe, discards pipeline warm-up samples, and rescales to 8 bits by round-half-up arithmetic right shift with saturation. Buffers results in a small FIFO and delivers them downstream over a valid/ready handshake. It forms the return path that brings filtered data back to the 8-bit sample domain the filter input uses.

Parameters:
IN_W, 16, input sample width (signed)
OUT_W, 8, output sample width (signed)
SHIFT, 3, right-shift amount for rescaling; 0 = no shift, no rounding
WARMUP, 5, number of initial valid input samples discarded after reset
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
CNT_W, 8, width of drop counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
y_in  in  IN_W  signed filter result
y_valid  in  1  y_in carries a new sample this cycle
s_data  out  OUT_W  signed rescaled sample, head of FIFO
s_valid  out  1  s_data valid (FIFO not empty)
s_ready  in  1  downstream accepts s_data this cycle
warm_done  out  1  warm-up complete, samples now kept
sat_flag  out  1  sticky: at least one sample saturated
drop_cnt  out  CNT_W  samples lost to FIFO-full, saturating
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at a rising edge): FIFO emptied; warm-up counter = WARMUP; stage register invalid. Outputs: s_valid=0, s_data=0, warm_done=(WARMUP==0), sat_flag=0, drop_cnt=0, fifo_level=0. Reset mid-stream discards all buffered and staged data. No output is produced in the cycle reset is released.
- Warm-up: while counter>0, each y_valid cycle decrements the counter and drops the sample. These drops do not count in drop_cnt. warm_done goes 1 in the cycle after the counter reaches 0 and stays 1 until reset.
- Rescale: r = (y_in + 2^(SHIFT-1)) >>> SHIFT, with the add done at IN_W+1 bits; SHIFT=0 gives r = y_in. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Any clip sets sat_flag, which stays set until reset.
- Stage: at edge E, with y_valid=1 and warm_done=1, the rescaled value is captured into the stage register. At edge E+1 the stage register is written to the FIFO. s_valid is high from the cycle after E+1 if the FIFO was empty. Fixed latency is 2 edges. The stage accepts a new sample every cycle, so throughput is 1 sample/clk.
- Pop: when s_valid && s_ready at an edge, the head is removed. s_data is always the current head and is held stable while s_valid && !s_ready.
- Full: if the FIFO is full at a stage write and no pop occurs in the same edge, the staged sample is dropped and drop_cnt increments, saturating at 2^CNT_W-1. A push and pop in the same edge while full are both performed; nothing is dropped and the level is unchanged.
- Empty: s_ready with FIFO empty has no effect. A push into an empty FIFO makes s_valid 1 the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH: push-only adds 1, pop-only subtracts 1, push+pop leaves it unchanged.
- y_in is ignored when y_valid=0.

Optional Feature:
FIR_REQUANT_SAT_EN
- Defined: saturation and sat_flag behave as described above.
- Undefined: no clipping. s_data takes the low OUT_W bits of r (two's-complement wrap), and sat_flag is tied to 0.

Test Plan:
- Reset release, WARMUP=5, feed y_valid with y_in=8 for 7 cycles -> first 5 dropped, warm_done=1 after the 5th; two outputs of 1 ((8+4)>>>3); drop_cnt=0.
- After warm-up, y_in = 100, -100, 0, -4 with s_ready=1 -> s_data = 13, -12, 0, 0 in order; s_valid first high 2 edges after the first capture; sat_flag=0.
- With FIR_REQUANT_SAT_EN, y_in=2000 then -2000 -> s_data = 127, -128; sat_flag=1 and stays 1 after y_in returns to 8. Without the macro -> s_data = -6, 6, and sat_flag=0.
- s_ready=0 with 10 consecutive valid samples after warm-up (depth 8) -> fifo_level=8, drop_cnt=2, s_data held at the first sample; then s_ready=1 drains 8 samples in order.
- FIFO full, s_ready=1 and continuous valid input -> fifo_level stays 8, drop_cnt does not change, and output order is preserved.
- Reset asserted with 4 entries buffered and the stage valid -> next cycle s_valid=0, fifo_level=0, drop_cnt=0, warm_done=0, and warm-up restarts.
